// File: rtl/tx_data_buffer_pkg.sv
// Shared USB transmit definitions: store_size encodings and default buffer depth.
// The AHB slave imports this package as well, so both sides agree on the encodings.
package tx_data_buffer_pkg;

  localparam int USB_TX_DEPTH = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } store_size_e;

  // Byte count for a store_size encoding; the illegal encoding carries no bytes.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/tx_data_buffer.sv
// Byte-wide transmit FIFO between the AHB-Lite slave (1/2/4-byte writes) and usb_tx
// (single-byte pops), with first-word fall-through head byte and error pulses.
module tx_data_buffer
  import tx_data_buffer_pkg::*;
#(
  parameter int DEPTH = USB_TX_DEPTH  // power of two, at most 64 so occupancy fits 7 bits
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        store_tx_data,
  input  logic [1:0]  store_size,
  input  logic [31:0] tx_data,
  input  logic        get_tx_packet_data,
  output logic [7:0]  tx_packet_data,
  output logic [6:0]  buffer_occupancy,
  output logic        full,
  output logic        overflow_err,
  output logic        underflow_err
);

  localparam int          PTR_W   = $clog2(DEPTH);
  localparam logic [7:0]  DEPTH_8 = 8'(DEPTH);
  localparam logic [6:0]  DEPTH_7 = 7'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [6:0]       occ_q, occ_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [2:0]       n_bytes;
  logic             wr_ok;
  logic             pop_ok;
  logic [3:0]       wr_en;
  logic [PTR_W-1:0] wr_idx [4];
  logic [7:0]       wr_byte [4];

  always_comb begin
    n_bytes = size_bytes(store_size);
    // Capacity check uses occupancy before any same-cycle pop; a pop gives no credit.
    wr_ok   = store_tx_data && (store_size != SIZE_ILLEGAL) &&
              (({1'b0, occ_q} + {5'b0, n_bytes}) <= DEPTH_8);
    pop_ok  = get_tx_packet_data && (occ_q != 7'd0);

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;

    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = 7'd0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + PTR_W'(n_bytes);
      if (pop_ok) rptr_d = rptr_q + PTR_W'(1);
      occ_d = occ_q + (wr_ok ? {4'b0, n_bytes} : 7'd0) - {6'b0, pop_ok};
      ovf_d = store_tx_data && !wr_ok;
      unf_d = get_tx_packet_data && (occ_q == 7'd0);
    end
    full_d = (occ_d == DEPTH_7);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_en[i]   = wr_ok && !clear && (3'(i) < n_bytes);
      wr_idx[i]  = wptr_q + PTR_W'(i);
      wr_byte[i] = tx_data[8*i +: 8];
    end
  end

  // Array is deliberately not reset; the empty gating on the output hides stale bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= wr_byte[i];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= 7'd0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign tx_packet_data   = (occ_q != 7'd0) ? mem[rptr_q] : 8'h00;
  assign buffer_occupancy = occ_q;
  assign full             = full_q;
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;

endmodule

// File: tb/tb_tx_data_buffer.sv
// Directed bench for tx_data_buffer: ordering, capacity limits, error pulses, clear and reset.
module tb_tx_data_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic        store_tx_data;
  logic [1:0]  store_size;
  logic [31:0] tx_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;
  logic        full;
  logic        overflow_err;
  logic        underflow_err;

  int checks   = 0;
  int failures = 0;

  tx_data_buffer #(.DEPTH(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .clear              (clear),
    .store_tx_data      (store_tx_data),
    .store_size         (store_size),
    .tx_data            (tx_data),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .full               (full),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] size, input logic [31:0] data);
    store_tx_data = 1'b1;
    store_size    = size;
    tx_data       = data;
    tick();
    store_tx_data = 1'b0;
  endtask

  // Head byte must already be valid in the cycle the pop strobe is high.
  task automatic pop_expect(input string tag, input logic [7:0] exp);
    get_tx_packet_data = 1'b1;
    chk(tag, {24'b0, tx_packet_data}, {24'b0, exp});
    tick();
    get_tx_packet_data = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int occ, input logic f,
                           input logic ovf, input logic unf);
    chk({tag, "_occ"}, {25'b0, buffer_occupancy}, 32'(occ));
    chk({tag, "_full"}, {31'b0, full}, {31'b0, f});
    chk({tag, "_ovf"}, {31'b0, overflow_err}, {31'b0, ovf});
    chk({tag, "_unf"}, {31'b0, underflow_err}, {31'b0, unf});
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; store_tx_data = 1'b0; store_size = 2'd0;
    tx_data = 32'h0; get_tx_packet_data = 1'b0;
    #12;
    chk_state("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset_data", {24'b0, tx_packet_data}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Word write, little-endian pop order
    write(2'd2, 32'hC3B2A1F0);
    chk_state("word", 4, 1'b0, 1'b0, 1'b0);
    pop_expect("word_b0", 8'hF0);
    pop_expect("word_b1", 8'hA1);
    pop_expect("word_b2", 8'hB2);
    pop_expect("word_b3", 8'hC3);
    chk_state("word_empty", 0, 1'b0, 1'b0, 1'b0);
    chk("word_empty_data", {24'b0, tx_packet_data}, 32'h0);

    // Pop while empty
    get_tx_packet_data = 1'b1;
    tick();
    get_tx_packet_data = 1'b0;
    chk_state("underflow", 0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("underflow_end", 0, 1'b0, 1'b0, 1'b0);
    write(2'd0, 32'h0000005A);
    chk_state("after_unf", 1, 1'b0, 1'b0, 1'b0);
    pop_expect("after_unf_b", 8'h5A);
    chk_state("after_unf_empty", 0, 1'b0, 1'b0, 1'b0);

    // Illegal size
    write(2'd3, 32'hDEADBEEF);
    chk_state("illegal", 0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("illegal_end", 0, 1'b0, 1'b0, 1'b0);

    // Fill with 16 words: byte j holds 8'h20 + j
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'(8'h20 + 4*w + b);
      write(2'd2, d);
    end
    chk_state("fill", 64, 1'b1, 1'b0, 1'b0);
    chk("fill_head", {24'b0, tx_packet_data}, 32'h20);
    write(2'd0, 32'h000000EE);
    chk_state("full_write", 64, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("full_write_end", 64, 1'b1, 1'b0, 1'b0);

    // Occupancy 62: word rejected, half accepted
    pop_expect("fill_b0", 8'h20);
    pop_expect("fill_b1", 8'h21);
    chk_state("occ62", 62, 1'b0, 1'b0, 1'b0);
    write(2'd2, 32'h11223344);
    chk_state("occ62_word", 62, 1'b0, 1'b1, 1'b0);
    write(2'd1, 32'h0000BEEF);
    chk_state("occ62_half", 64, 1'b1, 1'b0, 1'b0);
    for (int j = 2; j < 64; j++) pop_expect("drain", 8'(8'h20 + j));
    pop_expect("drain_ef", 8'hEF);
    pop_expect("drain_be", 8'hBE);
    chk_state("drained", 0, 1'b0, 1'b0, 1'b0);

    // Occupancy 10, simultaneous byte write and pop
    write(2'd2, 32'h63626160);
    write(2'd2, 32'h67666564);
    write(2'd1, 32'h00006968);
    chk_state("occ10", 10, 1'b0, 1'b0, 1'b0);
    store_tx_data = 1'b1; store_size = 2'd0; tx_data = 32'h00000070;
    get_tx_packet_data = 1'b1;
    chk("simul_head", {24'b0, tx_packet_data}, 32'h60);
    tick();
    store_tx_data = 1'b0; get_tx_packet_data = 1'b0;
    chk_state("simul", 10, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j < 10; j++) pop_expect("simul_drain", 8'(8'h60 + j));
    pop_expect("simul_tail", 8'h70);
    chk_state("simul_empty", 0, 1'b0, 1'b0, 1'b0);

    // Fill to 60 across the array end, then clear alongside a write
    for (int w = 0; w < 15; w++) write(2'd2, 32'h80818283 + 32'(w));
    chk_state("fill60", 60, 1'b0, 1'b0, 1'b0);
    chk("fill60_head", {24'b0, tx_packet_data}, 32'h83);
    clear = 1'b1; store_tx_data = 1'b1; store_size = 2'd2; tx_data = 32'hFFFFFFFF;
    tick();
    clear = 1'b0; store_tx_data = 1'b0;
    chk_state("clear", 0, 1'b0, 1'b0, 1'b0);
    chk("clear_data", {24'b0, tx_packet_data}, 32'h0);
    tick();
    chk_state("clear_after", 0, 1'b0, 1'b0, 1'b0);
    write(2'd0, 32'h000000A5);
    chk_state("post_clear", 1, 1'b0, 1'b0, 1'b0);
    pop_expect("post_clear_b", 8'hA5);

    // Asynchronous reset mid-packet
    write(2'd2, 32'h44332211);
    chk_state("pre_rst", 4, 1'b0, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk_state("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_data", {24'b0, tx_packet_data}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk_state("after_rst", 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
